// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// Operation codes above OP_SW are reserved and must be answered with an error.
package mips_cpu_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_DONE
    } lsu_state_t;

    function automatic logic op_is_reserved(logic [3:0] op);
        return op > 4'd9;
    endfunction

    function automatic logic op_is_load(lsu_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // LWL/LWR and byte accesses are legal at any offset.
    function automatic logic addr_misaligned(lsu_op_t op, logic [1:0] offset);
        case (op)
            OP_LH, OP_LHU, OP_SH: return offset[0];
            OP_LW, OP_SW:         return offset != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational byte-lane logic: extracts load results from a memory word and
// builds the read-modify-write word for sub-word stores (little-endian lanes).
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] rt_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [1:0]  inv_offset;
    logic [4:0]  shift_lo;
    logic [4:0]  shift_hi;
    logic [31:0] shifted;

    assign inv_offset = 2'd3 - offset;
    assign shift_lo   = {offset, 3'b000};
    assign shift_hi   = {inv_offset, 3'b000};
    assign shifted    = mem_word >> shift_lo;

    always_comb begin
        load_data = 32'd0;
        case (op)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'd0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'd0, shifted[15:0]};
            OP_LW:   load_data = mem_word;
            OP_LWL:  load_data = (mem_word << shift_hi) | (rt_data & ((32'd1 << shift_hi) - 32'd1));
            OP_LWR:  load_data = shifted | (rt_data & ~(32'hFFFF_FFFF >> shift_lo));
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        store_word = mem_word;
        case (op)
            OP_SB:   store_word = (mem_word & ~(32'h0000_00FF << shift_lo)) | ({24'd0, rt_data[7:0]} << shift_lo);
            OP_SH:   store_word = (mem_word & ~(32'h0000_FFFF << shift_lo)) | ({16'd0, rt_data[15:0]} << shift_lo);
            OP_SW:   store_word = rt_data;
            default: store_word = mem_word;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one request at a time, word-only memory, sub-word stores
// done as read-modify-write. All outputs come straight from registers.
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    lsu_state_t  state_q, state_d;
    lsu_op_t     op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] data_address_q, data_address_d;
    logic        data_read_q, data_read_d;
    logic        data_write_q, data_write_d;
    logic [31:0] data_writedata_q, data_writedata_d;

    lsu_op_t     req_op_e;
    logic        req_bad;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_op_e = lsu_op_t'(req_op);
    assign req_bad  = op_is_reserved(req_op) || addr_misaligned(req_op_e, req_addr[1:0]);

    // Memory data is only valid during MERGE; afterwards the captured copy is used.
    assign align_word = (state_q == ST_MERGE) ? data_readdata : word_q;

    mips_cpu_lsu_align u_align (
        .op         (op_q),
        .offset     (off_q),
        .mem_word   (align_word),
        .rt_data    (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        off_d            = off_q;
        wdata_d          = wdata_q;
        word_d           = word_q;
        req_ready_d      = 1'b0;
        resp_valid_d     = 1'b0;
        resp_data_d      = resp_data_q;
        resp_err_d       = resp_err_q;
        data_address_d   = data_address_q;
        data_read_d      = 1'b0;
        data_write_d     = 1'b0;
        data_writedata_d = data_writedata_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    op_d        = req_op_e;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    resp_data_d = 32'd0;
                    resp_err_d  = 1'b0;
                    req_ready_d = 1'b0;
                    if (req_bad) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_op_e == OP_SW) begin
                        state_d          = ST_WRITE;
                        data_address_d   = {req_addr[31:2], 2'b00};
                        data_write_d     = 1'b1;
                        data_writedata_d = req_wdata;
                    end else begin
                        state_d        = ST_READ;
                        data_address_d = {req_addr[31:2], 2'b00};
                        data_read_d    = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_MERGE;
            end
            ST_MERGE: begin
                word_d = data_readdata;
                if (op_is_load(op_q)) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_data;
                end else begin
                    state_d          = ST_WRITE;
                    data_write_d     = 1'b1;
                    data_writedata_d = store_word;
                end
            end
            ST_WRITE: begin
                state_d      = ST_DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = 32'd0;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            op_q             <= OP_LB;
            off_q            <= 2'd0;
            wdata_q          <= 32'd0;
            word_q           <= 32'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= 32'd0;
            resp_err_q       <= 1'b0;
            data_address_q   <= 32'd0;
            data_read_q      <= 1'b0;
            data_write_q     <= 1'b0;
            data_writedata_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            off_q            <= off_d;
            wdata_q          <= wdata_d;
            word_q           <= word_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_err_q       <= resp_err_d;
            data_address_q   <= data_address_d;
            data_read_q      <= data_read_d;
            data_write_q     <= data_write_d;
            data_writedata_q <= data_writedata_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_err       = resp_err_q;
    assign data_address   = data_address_q;
    assign data_read      = data_read_q;
    assign data_write     = data_write_q;
    assign data_writedata = data_writedata_q;

endmodule
